// File: rtl/digit_serial_addsub_if.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub_if
//   Operand/result bus of the digit-serial adder/subtractor.
//
//   Operand side : in_valid / in_ready handshake carrying A, B and SUB.
//   Result side  : out_valid / out_ready handshake carrying RESULT,
//                  CARRY_BORROW and OVERFLOW.
//
//   Modports:
//     master - operand source / result consumer (drives operands, out_ready)
//     slave  - the arithmetic block (drives in_ready, results, flags)
//
//   Parameter N : operand/result width in bits.
// ---------------------------------------------------------------------------
interface digit_serial_addsub_if #(
    parameter int N = 8
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         SUB;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] RESULT;
    logic         CARRY_BORROW;
    logic         OVERFLOW;

    modport master (
        output in_valid,
        output A,
        output B,
        output SUB,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  RESULT,
        input  CARRY_BORROW,
        input  OVERFLOW
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  SUB,
        input  out_ready,
        output in_ready,
        output out_valid,
        output RESULT,
        output CARRY_BORROW,
        output OVERFLOW
    );

endinterface

// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//   Multi-cycle two's-complement adder/subtractor. An N-bit operand pair is
//   processed D bits per clock, least-significant digit first, so a result
//   is produced N/D cycles after the operands are accepted.
//
//   Ports:
//     clk    - system clock, rising edge active
//     rst_n  - asynchronous active-low reset
//     bus    - digit_serial_addsub_if.slave
//                in_valid/in_ready  operand handshake (in_ready high in IDLE)
//                A, B, SUB          operands and mode (0: A+B, 1: A-B)
//                out_valid/out_ready result handshake
//                RESULT             sum/difference modulo 2^N
//                CARRY_BORROW       add: carry out, sub: borrow (= ~carry)
//                OVERFLOW           signed overflow
//
//   Parameters:
//     N - operand width, N >= 2
//     D - digit width, must divide N; D == N gives single-cycle compute
//
//   Build option:
//     ADDSUB_SAT_EN - when defined, RESULT clamps to the signed limits on
//                     overflow (flags still report the raw condition). When
//                     undefined RESULT wraps and no clamp logic exists.
//
//   RESULT and the flags only change on the completing edge; they hold the
//   previous result through IDLE and RUN.
// ---------------------------------------------------------------------------
module digit_serial_addsub #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_serial_addsub_if.slave  bus
);

    localparam int NDIG  = N / D;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     part_q, part_d;
    logic [N-1:0]     result_q, result_d;
    logic             cb_q, cb_d;
    logic             ovf_q, ovf_d;

`ifdef ADDSUB_SAT_EN
    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    // On overflow the sign of A tells which way the true result ran off:
    // A non-negative means it overflowed upwards.
    function automatic logic [N-1:0] saturate(input logic [N-1:0] raw,
                                              input logic         ovf,
                                              input logic         a_neg);
        if (!ovf) begin
            return raw;
        end
        return a_neg ? SAT_MIN : SAT_MAX;
    endfunction
`endif

    // ---- digit slice: one D-bit add per cycle ----
    logic [D-1:0]   a_dig;
    logic [D-1:0]   b_dig;
    logic [D:0]     dig_sum;
    logic           cin_msb;
    logic           ovf_next;
    logic [N+D-1:0] part_cat;
    logic [N-1:0]   part_next;

    always_comb begin
        a_dig   = a_q[int'(cnt_q) * D +: D];
        b_dig   = b_q[int'(cnt_q) * D +: D];
        dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + (D+1)'(carry_q);
        // Sum bit = a ^ b ^ cin, so the carry that entered the top bit of
        // the digit can be recovered from the sum without a second adder.
        cin_msb  = dig_sum[D-1] ^ a_dig[D-1] ^ b_dig[D-1];
        ovf_next = cin_msb ^ dig_sum[D];
        // New digit enters at the top; after N/D shifts the first digit
        // sits at bit 0 and the partial register holds the full result.
        part_cat  = {dig_sum[D-1:0], part_q};
        part_next = part_cat[N+D-1:D];
    end

    // ---- control / next state ----
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        result_d = result_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    // Subtraction is A + ~B + 1: invert here, carry-in 1.
                    b_d     = bus.B ^ {N{bus.SUB}};
                    carry_d = bus.SUB;
                    mode_d  = bus.SUB;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                carry_d = dig_sum[D];
                part_d  = part_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIG) begin
`ifdef ADDSUB_SAT_EN
                    result_d = saturate(part_next, ovf_next, a_q[N-1]);
`else
                    result_d = part_next;
`endif
                    cb_d    = dig_sum[D] ^ mode_q;
                    ovf_d   = ovf_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // in_valid is deliberately ignored here; a new operand is
                // only taken once back in IDLE.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- state registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
        end
    end

    // ---- outputs ----
    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.RESULT       = result_q;
    assign bus.CARRY_BORROW = cb_q;
    assign bus.OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_addsub
//   Directed bench for digit_serial_addsub. Two instances share clock and
//   reset: one with N=8, D=2 (4-cycle latency) and one with N=8, D=8
//   (single-cycle compute). A transaction-level model predicts handshakes,
//   result and flags from plain integer arithmetic; a compare process checks
//   both instances against it every cycle. Directed cases also check
//   hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_digit_serial_addsub;

    localparam int N = 8;

`ifdef ADDSUB_SAT_EN
    localparam logic [7:0] R_7F01 = 8'h7F;
    localparam logic [7:0] R_8001 = 8'h80;
    localparam logic [7:0] R_8080 = 8'h80;
    localparam logic [7:0] R_AA55 = 8'h80;
`else
    localparam logic [7:0] R_7F01 = 8'h80;
    localparam logic [7:0] R_8001 = 8'h7F;
    localparam logic [7:0] R_8080 = 8'h00;
    localparam logic [7:0] R_AA55 = 8'h55;
`endif

    typedef struct packed {
        logic [7:0] res;
        logic       cb;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, index 0 -> D=2 instance, index 1 -> D=8 instance.
    logic [1:0]      iv   = '0;
    logic [1:0]      isub = '0;
    logic [1:0]      ordy = '0;
    logic [1:0][7:0] ia   = '0;
    logic [1:0][7:0] ib   = '0;

    logic [1:0]      irdy;
    logic [1:0]      ov;
    logic [1:0]      cbo;
    logic [1:0]      ovo;
    logic [1:0][7:0] res;

    digit_serial_addsub_if #(.N(N)) if0 ();
    digit_serial_addsub_if #(.N(N)) if1 ();

    assign if0.in_valid  = iv[0];
    assign if0.A         = ia[0];
    assign if0.B         = ib[0];
    assign if0.SUB       = isub[0];
    assign if0.out_ready = ordy[0];
    assign if1.in_valid  = iv[1];
    assign if1.A         = ia[1];
    assign if1.B         = ib[1];
    assign if1.SUB       = isub[1];
    assign if1.out_ready = ordy[1];

    assign irdy = {if1.in_ready, if0.in_ready};
    assign ov   = {if1.out_valid, if0.out_valid};
    assign cbo  = {if1.CARRY_BORROW, if0.CARRY_BORROW};
    assign ovo  = {if1.OVERFLOW, if0.OVERFLOW};
    assign res  = {if1.RESULT, if0.RESULT};

    digit_serial_addsub #(.N(N), .D(2)) dut_d2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    digit_serial_addsub #(.N(N), .D(8)) dut_d8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic exp_t mk(input logic [7:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r;
        e.cb  = c;
        e.ovf = o;
        return e;
    endfunction

    // Arithmetic reference: unsigned integers give result and carry/borrow,
    // signed integers give overflow and the clamp direction.
    function automatic exp_t model_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur   = ua - ub;
            sr   = sa - sb;
            e.cb = (ua < ub);
        end else begin
            ur   = ua + ub;
            sr   = sa + sb;
            e.cb = (ur > 255);
        end
        e.res = ur[7:0];
        e.ovf = (sr > 127) || (sr < -128);
`ifdef ADDSUB_SAT_EN
        if (e.ovf) e.res = (sr > 0) ? 8'h7F : 8'h80;
`endif
        return e;
    endfunction

    // Transaction model: busy from accept until result handshake, done once
    // the latency has elapsed; held is what the result outputs must show.
    logic [1:0] m_busy = '0;
    logic [1:0] m_done = '0;
    int         m_acc [2];
    exp_t       m_pend[2];
    exp_t       m_held[2];
    int         ecount = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= '0;
            m_done    <= '0;
            m_held[0] <= '0;
            m_held[1] <= '0;
        end else begin
            ecount <= ecount + 1;
            for (int i = 0; i < 2; i++) begin
                if (!m_busy[i]) begin
                    if (iv[i]) begin
                        m_busy[i] <= 1'b1;
                        m_acc[i]  <= ecount;
                        m_pend[i] <= model_op(ia[i], ib[i], isub[i]);
                    end
                end else if (!m_done[i]) begin
                    if (ecount - m_acc[i] == lat_of(i)) begin
                        m_done[i] <= 1'b1;
                        m_held[i] <= m_pend[i];
                    end
                end else if (ordy[i]) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready[%0d]", i),  irdy[i], !m_busy[i]);
                chk($sformatf("out_valid[%0d]", i), ov[i],   m_done[i]);
                chk($sformatf("RESULT[%0d]", i),    res[i],  m_held[i].res);
                chk($sformatf("CARRY_BORROW[%0d]", i), cbo[i], m_held[i].cb);
                chk($sformatf("OVERFLOW[%0d]", i),  ovo[i],  m_held[i].ovf);
            end
        end
    end

    // Counts negedges after the current point until out_valid[i] is seen.
    task automatic wait_done(input int i, output int n, output logic ok);
        ok = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ov[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input exp_t lit, input int hold);
        int   n;
        logic ok;
        exp_t m;
        m = model_op(a, b, sub);
        chk("model_pin_res", m.res, lit.res);
        chk("model_pin_cb",  m.cb,  lit.cb);
        chk("model_pin_ovf", m.ovf, lit.ovf);
        @(negedge clk);
        #1;
        iv[i] = 1'b1; ia[i] = a; ib[i] = b; isub[i] = sub; ordy[i] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (irdy[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        wait_done(i, n, ok);
        chk("done_timeout", ok, 1);
        chk($sformatf("latency[%0d]", i), n - 1, lat_of(i));
        chk($sformatf("lit_res %0h%s%0h", a, sub ? "-" : "+", b), res[i], lit.res);
        chk($sformatf("lit_cb %0h%s%0h", a, sub ? "-" : "+", b),  cbo[i], lit.cb);
        chk($sformatf("lit_ovf %0h%s%0h", a, sub ? "-" : "+", b), ovo[i], lit.ovf);
        repeat (hold) @(negedge clk);
        #1;
        ordy[i] = 1'b1;
        @(posedge clk);
        #1;
        ordy[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic ok;
        logic seen;

        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  irdy[0], 1);
        chk("rst_out_valid", ov[0],   0);
        chk("rst_result",    res[0],  0);
        #1;
        rst_n = 1'b1;

        // Basic add/sub, carry and borrow, signed overflow, equal operands.
        do_op(0, 8'h35, 8'h12, 1'b0, mk(8'h47, 1'b0, 1'b0), 0);
        do_op(0, 8'h05, 8'h09, 1'b1, mk(8'hFC, 1'b1, 1'b0), 0);
        do_op(0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), 0);
        do_op(0, 8'h7F, 8'h01, 1'b0, mk(R_7F01, 1'b0, 1'b1), 0);
        do_op(0, 8'h80, 8'h01, 1'b1, mk(R_8001, 1'b0, 1'b1), 0);
        do_op(0, 8'h5A, 8'h5A, 1'b1, mk(8'h00, 1'b0, 1'b0), 0);
        do_op(0, 8'h80, 8'h80, 1'b0, mk(R_8080, 1'b1, 1'b1), 0);
        do_op(0, 8'h12, 8'h34, 1'b0, mk(8'h46, 1'b0, 1'b0), 3);
        do_op(1, 8'h7F, 8'h01, 1'b0, mk(R_7F01, 1'b0, 1'b1), 0);
        do_op(1, 8'h05, 8'h09, 1'b1, mk(8'hFC, 1'b1, 1'b0), 1);

        // Result held back while new operands wait on in_valid.
        @(negedge clk);
        #1;
        iv[0] = 1'b1; ia[0] = 8'h3C; ib[0] = 8'h11; isub[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        wait_done(0, n, ok);
        chk("hold_done_timeout", ok, 1);
        #1;
        iv[0] = 1'b1; ia[0] = 8'h01; ib[0] = 8'h02; isub[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", ov[0],   1);
            chk("hold_result",    res[0],  8'h4D);
            chk("hold_in_ready",  irdy[0], 0);
        end
        #1;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        @(negedge clk);
        chk("after_hs_in_ready",  irdy[0], 1);
        chk("after_hs_out_valid", ov[0],   0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        wait_done(0, n, ok);
        chk("second_done_timeout", ok, 1);
        chk("second_latency", n - 1, 4);
        chk("second_result", res[0], 8'h03);
        #1;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;

        // Reset after two digits of AA-55 on the D=2 instance.
        @(negedge clk);
        #1;
        iv[0] = 1'b1; ia[0] = 8'hAA; ib[0] = 8'h55; isub[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_in_ready",  irdy[0], 1);
        chk("midrun_rst_out_valid", ov[0],   0);
        chk("midrun_rst_result",    res[0],  0);
        chk("midrun_rst_cb",        cbo[0],  0);
        chk("midrun_rst_ovf",       ovo[0],  0);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        chk("no_completion_after_rst", seen, 0);

        do_op(1, 8'hAA, 8'h55, 1'b1, mk(R_AA55, 1'b0, 1'b1), 0);
        do_op(0, 8'hAA, 8'h55, 1'b1, mk(R_AA55, 1'b0, 1'b1), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor that processes an N-bit operand pair D bits per clock. It succeeds the purely combinational N-bit ripple subtractor, trading latency (N/D cycles) for a D-bit-wide adder slice. It adds a runtime add/sub mode, signed overflow detection and valid/ready handshakes on input and output. It sits between an operand source and a result consumer in the arithmetic datapath.

Parameters:
N, 8, operand/result width in bits; must be >= 2.
D, 2, digit width processed per cycle; must divide N exactly; D = N gives single-cycle compute.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair and mode are valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  N  minuend / first addend
B  input  N  subtrahend / second addend
SUB  input  1  0 = A+B, 1 = A-B; sampled with operands
out_valid  output  1  RESULT/flags hold a completed operation
out_ready  input  1  consumer accepts result
RESULT  output  N  sum or difference, modulo 2^N (or saturated, see Optional Feature)
CARRY_BORROW  output  1  add: carry out of MSB; sub: borrow = NOT carry out
OVERFLOW  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, digit counter 0, carry register 0, operand/partial registers 0; RESULT=0, CARRY_BORROW=0, OVERFLOW=0, out_valid=0. in_ready=1, since it is decoded from state==IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at an edge, capture A, and B XOR {N{SUB}}. Set carry register to SUB, set counter to 0, latch mode, and go to RUN.
- RUN: in_ready=0. Each edge adds digit [k*D +: D] of both operand registers plus the carry register. The D-bit sum is shifted into an internal partial register, the carry register is updated, and the counter increments. On the edge processing digit N/D-1:
  - Load RESULT from the completed partial register.
  - CARRY_BORROW = cout XOR mode.
  - OVERFLOW = carry-into-MSB XOR cout.
  - Assert out_valid and go to DONE.
- Latency: out_valid rises exactly N/D cycles after the accepting edge; with N=8, D=2, that is 4 cycles.
- DONE: out_valid=1; RESULT and flags stable. On out_ready at an edge, clear out_valid and go to IDLE. in_valid is ignored while in RUN or DONE.
- Throughput: one operation per N/D+2 cycles at best, counting the accept, N/D compute edges, the DONE handshake, and the return to IDLE.
- RESULT, CARRY_BORROW and OVERFLOW change only at completion. They hold the previous result through IDLE and RUN, and are meaningful only while out_valid=1.
- Simultaneous in_valid and out_ready in DONE: only out_ready acts; the operand is not accepted until IDLE.
- Reset mid-RUN or mid-DONE: the operation is discarded, no out_valid is produced, and all registers return to reset values.
- Subtraction uses ~B with carry-in 1. A-B with A==B gives RESULT=0 and CARRY_BORROW=0.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined: on OVERFLOW=1, RESULT clamps to signed limits. If the true result is positive (MSB of A is 0), RESULT = {1'b0,{N-1{1'b1}}}. If negative, RESULT = {1'b1,{N-1{1'b0}}}. OVERFLOW and CARRY_BORROW still report the raw condition.
- Undefined: RESULT wraps modulo 2^N. No saturation logic is instantiated.

Test Plan:
1. N=8, D=2, A=8'h35, B=8'h12, SUB=0 -> out_valid 4 cycles after accept; RESULT=8'h47, CARRY_BORROW=0, OVERFLOW=0.
2. A=8'h05, B=8'h09, SUB=1 -> RESULT=8'hFC, CARRY_BORROW=1, OVERFLOW=0. Also A=8'hFF, B=8'h01, SUB=0 -> RESULT=8'h00, CARRY_BORROW=1, OVERFLOW=0.
3. A=8'h7F, B=8'h01, SUB=0 -> OVERFLOW=1, CARRY_BORROW=0; RESULT=8'h80 without ADDSUB_SAT_EN, 8'h7F with it.
4. A=8'h80, B=8'h01, SUB=1 -> OVERFLOW=1, CARRY_BORROW=0; RESULT=8'h7F without ADDSUB_SAT_EN, 8'h80 with it.
5. Hold out_ready=0 for 5 cycles after completion, driving in_valid=1 with new operands -> out_valid held, RESULT stable, in_ready=0, new operands not accepted until one cycle after the out_ready handshake.
6. Assert rst_n=0 after 2 digits of 8'hAA-8'h55 -> in_ready=1; RESULT, flags and out_valid all 0; no completion follows. Then rerun the case with D=8 -> out_valid 1 cycle after accept, RESULT=8'h55.
